// File: rtl/ans_decoder_pkg.sv
// Shared constants, FSM encoding and lookup result type for the rANS decoder.
package ans_decoder_pkg;

  localparam int NUM_SYMS    = 16;
  localparam int SYM_IDX_W   = 4;
  localparam int TOTAL_LOG2  = 8;
  localparam int CNT_WIDTH   = 9;
  localparam int STATE_WIDTH = 12;
  localparam int SYM_WIDTH   = 4;
  localparam int LEN_WIDTH   = 16;

  // One extra bit so decode arithmetic never wraps before truncation.
  localparam int XW = STATE_WIDTH + 1;

  // M = 2**TOTAL_LOG2, the lower bound of the normalised state interval.
  localparam logic [STATE_WIDTH-1:0] M_VAL     = STATE_WIDTH'(1 << TOTAL_LOG2);
  // Encoder start value; a clean stream decodes back to exactly this.
  localparam logic [STATE_WIDTH-1:0] START_VAL = STATE_WIDTH'((1 << TOTAL_LOG2) + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_EMIT   = 3'd2,
    ST_RENORM = 3'd3,
    ST_FINISH = 3'd4
  } dec_state_e;

  typedef struct packed {
    logic                   hit;
    logic [SYM_IDX_W-1:0]   idx;
    logic [CNT_WIDTH-1:0]   count;
    logic [STATE_WIDTH-1:0] cum;
  } lookup_t;

endpackage

// File: rtl/ans_decoder_freq_table.sv
// Frequency table: NUM_SYMS x {count, cum} registers with one write port and
// a combinational slot -> symbol priority lookup (lowest matching index wins).
module ans_freq_table
  import ans_decoder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [SYM_IDX_W-1:0]   addr,
  input  logic [CNT_WIDTH-1:0]   wr_count,
  input  logic [STATE_WIDTH-1:0] wr_cum,
  input  logic [TOTAL_LOG2-1:0]  slot,
  output lookup_t                result
);

  logic [CNT_WIDTH-1:0]   count_q [NUM_SYMS];
  logic [STATE_WIDTH-1:0] cum_q   [NUM_SYMS];

  // True when slot falls inside [cum, cum+count) of a non-empty entry.
  function automatic logic in_range(input logic [TOTAL_LOG2-1:0]  s,
                                    input logic [CNT_WIDTH-1:0]   c,
                                    input logic [STATE_WIDTH-1:0] base);
    logic [XW-1:0] lo;
    logic [XW-1:0] hi;
    logic [XW-1:0] sv;
    lo = XW'(base);
    hi = XW'(base) + XW'(c);
    sv = XW'(s);
    return (c != '0) && (sv >= lo) && (sv < hi);
  endfunction

  // Table write port; entries clear on reset.
  // NOTE: the table is small and must read as all-zero after reset, so it is
  // built from resettable flops rather than a RAM macro that cannot be cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYMS; i++) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        count_q[i] <= '0;
        cum_q[i]   <= '0;
      end
    end else if (we) begin
      count_q[addr] <= wr_count;
      cum_q[addr]   <= wr_cum;
    end
  end

  // Priority lookup: scan high to low so the lowest matching index is kept.
  always_comb begin
    // NOTE: default first so no path leaves result unassigned (no latch).
    result = '0;
    for (int i = NUM_SYMS - 1; i >= 0; i--) begin
      if (in_range(slot, count_q[i], cum_q[i])) begin
        result.hit   = 1'b1;
        result.idx   = SYM_IDX_W'(i);
        result.count = count_q[i];
        result.cum   = cum_q[i];
      end
    end
  end

endmodule

// File: rtl/ans_decoder.sv
// Streaming rANS decoder: reloads the encoder's final state, emits symbols,
// pulls renorm nibbles and reports whether the state returned to M+1.
module ans_decoder
  import ans_decoder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   tbl_we,
  input  logic [SYM_IDX_W-1:0]   tbl_addr,
  input  logic [CNT_WIDTH-1:0]   tbl_count,
  input  logic [STATE_WIDTH-1:0] tbl_cum,
  input  logic                   init_vld,
  output logic                   init_rdy,
  input  logic [STATE_WIDTH-1:0] init_state,
  input  logic [LEN_WIDTH-1:0]   init_len,
  input  logic [SYM_WIDTH-1:0]   in,
  input  logic                   in_vld,
  output logic                   in_rdy,
  output logic [SYM_IDX_W-1:0]   out,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  dec_state_e             state_q;
  logic [STATE_WIDTH-1:0] x;
  logic [LEN_WIDTH-1:0]   remaining_q;

  logic                   tbl_wr_en;
  lookup_t                lk;
  logic [XW-1:0]          decoded_x;
  logic [STATE_WIDTH-1:0] shifted_x;

  // Writes only land while idle; a write alongside an init handshake is
  // visible by the time LOOKUP reads the table.
  assign tbl_wr_en = ena && tbl_we && (state_q == ST_IDLE);

  ans_freq_table u_tbl (
    .clk      (clk),
    .rst      (rst),
    .we       (tbl_wr_en),
    .addr     (tbl_addr),
    .wr_count (tbl_count),
    .wr_cum   (tbl_cum),
    .slot     (x[TOTAL_LOG2-1:0]),
    .result   (lk)
  );

  // Decode step x' = count*(x>>TL) + slot - cum, widened to avoid wrap.
  assign decoded_x = XW'(lk.count) * XW'(x >> TOTAL_LOG2)
                   + XW'(x[TOTAL_LOG2-1:0]) - XW'(lk.cum);

  // Renorm step; only taken while x < M, so nothing is shifted out.
  assign shifted_x = {x[STATE_WIDTH-SYM_WIDTH-1:0], in};

  assign init_rdy = ena && (state_q == ST_IDLE);
  assign in_rdy   = ena && (state_q == ST_RENORM) && (x < M_VAL);
  assign busy     = (state_q != ST_IDLE);

  // Decoder FSM with registered symbol, done and err outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x           <= '0;
      remaining_q <= '0;
      out         <= '0;
      out_vld     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (init_vld) begin
            x           <= init_state;
            remaining_q <= init_len;
            done        <= 1'b0;
            err         <= 1'b0;
            state_q     <= (init_len == '0) ? ST_FINISH : ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lk.hit) begin
            x       <= decoded_x[STATE_WIDTH-1:0];
            out     <= lk.idx;
            out_vld <= 1'b1;
            state_q <= ST_EMIT;
          end else begin
            err     <= 1'b1;
            done    <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (out_rdy) begin
            out_vld     <= 1'b0;
            remaining_q <= remaining_q - 1'b1;
            state_q     <= ST_RENORM;
          end
        end
        ST_RENORM: begin
          if (x < M_VAL) begin
            if (in_vld) x <= shifted_x;
          end else begin
            state_q <= (remaining_q == '0) ? ST_FINISH : ST_LOOKUP;
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          err     <= (x != START_VAL);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_decoder.sv
// Directed bench for ans_decoder with hand-computed expectations (M = 256).
module tb_ans_decoder;
  import ans_decoder_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ena;
  logic                   tbl_we;
  logic [SYM_IDX_W-1:0]   tbl_addr;
  logic [CNT_WIDTH-1:0]   tbl_count;
  logic [STATE_WIDTH-1:0] tbl_cum;
  logic                   init_vld;
  logic                   init_rdy;
  logic [STATE_WIDTH-1:0] init_state;
  logic [LEN_WIDTH-1:0]   init_len;
  logic [SYM_WIDTH-1:0]   in_nib;
  logic                   in_vld;
  logic                   in_rdy;
  logic [SYM_IDX_W-1:0]   out;
  logic                   out_vld;
  logic                   out_rdy;
  logic                   busy;
  logic                   done;
  logic                   err;

  int checks = 0;
  int errors = 0;
  logic saw_in_rdy;
  logic saw_out_vld;

  always #5 clk = ~clk;

  ans_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_count  (tbl_count),
    .tbl_cum    (tbl_cum),
    .init_vld   (init_vld),
    .init_rdy   (init_rdy),
    .init_state (init_state),
    .init_len   (init_len),
    .in         (in_nib),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .out        (out),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_tbl(input int a, input int c, input int cm);
    tbl_we    = 1'b1;
    tbl_addr  = SYM_IDX_W'(a);
    tbl_count = CNT_WIDTH'(c);
    tbl_cum   = STATE_WIDTH'(cm);
    tick();
    tbl_we    = 1'b0;
  endtask

  // Init handshake; on return the DUT is in LOOKUP (or FINISH for len 0).
  task automatic start(input int st, input int len);
    init_vld   = 1'b1;
    init_state = STATE_WIDTH'(st);
    init_len   = LEN_WIDTH'(len);
    tick();
    init_vld   = 1'b0;
  endtask

  // Run until done with a bounded budget, noting any in_rdy / out_vld seen.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (in_rdy === 1'b1) saw_in_rdy = 1'b1;
      if (out_vld === 1'b1) saw_out_vld = 1'b1;
      tick();
      n++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_count = '0;
    tbl_cum = '0; init_vld = 1'b0; init_state = '0; init_len = '0;
    in_nib = '0; in_vld = 1'b0; out_rdy = 1'b1;
    saw_in_rdy = 1'b0; saw_out_vld = 1'b0;

    // Reset state
    do_reset();
    check("rst_init_rdy", init_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_out", out, 0);
    check("rst_x", dut.x, 0);
    ena = 1'b0;
    #1;
    check("ena0_init_rdy", init_rdy, 0);
    ena = 1'b1;

    // Case 1: 513 -> slot 1, x = 128*2+1 = 257, no renorm, clean finish
    write_tbl(0, 128, 0);
    write_tbl(1, 128, 128);
    start(513, 1);
    check("c1_busy", busy, 1);
    tick();
    check("c1_out_vld", out_vld, 1);
    check("c1_out", out, 0);
    check("c1_x", dut.x, 257);
    saw_in_rdy = 1'b0;
    wait_done("c1");
    check("c1_no_in_rdy", saw_in_rdy, 0);
    check("c1_err", err, 0);
    check("c1_final_x", dut.x, 257);

    // Case 2: 256 -> slot 0, x = 16; feed 1 -> 257
    do_reset();
    write_tbl(0, 16, 0);
    write_tbl(1, 240, 16);
    start(256, 1);
    tick();
    check("c2_out_vld", out_vld, 1);
    check("c2_out", out, 0);
    check("c2_in_rdy_emit", in_rdy, 0);
    tick();
    check("c2_in_rdy", in_rdy, 1);
    check("c2_x16", dut.x, 16);
    in_nib = 4'd1; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    check("c2_x257", dut.x, 257);
    check("c2_in_rdy_off", in_rdy, 0);
    wait_done("c2");
    check("c2_err", err, 0);

    // Case 3: 257 -> slot 1, x = 17; feed 0 -> 272 -> err
    start(257, 1);
    check("c3_done_cleared", done, 0);
    tick();
    check("c3_out", out, 0);
    tick();
    check("c3_x17", dut.x, 17);
    in_nib = 4'd0; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    check("c3_x272", dut.x, 272);
    wait_done("c3");
    check("c3_err", err, 1);

    // Case 4: only entry 0 present, 300 -> slot 44 misses
    do_reset();
    write_tbl(0, 16, 0);
    saw_out_vld = 1'b0;
    start(300, 1);
    wait_done("c4");
    check("c4_err", err, 1);
    check("c4_no_out_vld", saw_out_vld, 0);
    check("c4_idle", busy, 0);

    // Zero-length decodes finish straight away from the loaded state
    start(257, 0);
    wait_done("len0a");
    check("len0a_err", err, 0);
    start(300, 0);
    wait_done("len0b");
    check("len0b_err", err, 1);

    // Case 5: case 2 with the sink stalled for 5 cycles
    do_reset();
    write_tbl(0, 16, 0);
    write_tbl(1, 240, 16);
    out_rdy = 1'b0;
    start(256, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("c5_stall_vld", out_vld, 1);
      check("c5_stall_out", out, 0);
      check("c5_stall_in_rdy", in_rdy, 0);
      check("c5_stall_x", dut.x, 16);
      tick();
    end
    out_rdy = 1'b1;
    tick();
    check("c5_out_vld_low", out_vld, 0);
    check("c5_in_rdy", in_rdy, 1);
    in_nib = 4'd1; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    wait_done("c5");
    check("c5_err", err, 0);

    // Case 6: ignored write while busy, then reset in RENORM
    start(256, 1);
    tick();
    tick();
    check("c6_in_renorm", in_rdy, 1);
    write_tbl(2, 77, 5);
    check("c6_write_ignored", dut.u_tbl.count_q[2], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("c6_init_rdy", init_rdy, 1);
    check("c6_busy", busy, 0);
    check("c6_in_rdy", in_rdy, 0);
    check("c6_done", done, 0);
    check("c6_x", dut.x, 0);
    check("c6_tbl0", dut.u_tbl.count_q[0], 0);
    // Table is empty now, so any decode misses
    start(256, 1);
    wait_done("c6_miss");
    check("c6_miss_err", err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
